hw_accel_rgb2gray_ctrl: RTL

- Frame-level sequencer for the PPC-wide RGB-to-grayscale conversion stage in the hw_accel pipeline.
- On a start command it latches the frame geometry and admits exactly one frame of RGB beats through a valid/ready handshake.
- It converts each pixel to gray through a 2-stage pipeline and tags output beats with frame and line markers.
- It reports completion to the host or DMA side, and supports abort and a running frame count.

---
 rtl/hw_accel_rgb2gray_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hw_accel_rgb2gray_ctrl.sv
// Frame sequencer for the RGB-to-gray stage: latches geometry on start, admits one frame of
// PPC-wide RGB beats, converts through a 2-stage pipeline and tags frame/line markers.
module hw_accel_rgb2gray_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PPC        = 2,
  parameter int unsigned DIM_W      = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIM_W-1:0]          cfg_width,
  input  logic [DIM_W-1:0]          cfg_height,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               frame_cnt,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PPC*DATA_WIDTH-1:0] in_red,
  input  logic [PPC*DATA_WIDTH-1:0] in_green,
  input  logic [PPC*DATA_WIDTH-1:0] in_blue,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PPC*DATA_WIDTH-1:0] out_gray,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic                      out_eof
);

  localparam int unsigned PixW  = PPC * DATA_WIDTH;
  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  // Coefficients sum to 256, so the weighted sum always fits in DATA_WIDTH+8 bits.
  localparam int unsigned SumW  = DATA_WIDTH + 8;

  localparam logic [ProdW-1:0] CoefR = ProdW'(77);
  localparam logic [ProdW-1:0] CoefG = ProdW'(150);
  localparam logic [ProdW-1:0] CoefB = ProdW'(29);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            r_state;
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_height;
  logic [DIM_W-1:0]  r_x;
  logic [DIM_W-1:0]  r_y;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_frame_cnt;

  // Stage 1: per-lane weighted products plus sideband flags.
  logic              r_s1_valid;
  logic [ProdW-1:0]  r_s1_r [PPC];
  logic [ProdW-1:0]  r_s1_g [PPC];
  logic [ProdW-1:0]  r_s1_b [PPC];
  logic              r_s1_sof;
  logic              r_s1_eol;
  logic              r_s1_eof;

  // Stage 2: output beat.
  logic              r_out_valid;
  logic [PixW-1:0]   r_out_gray;
  logic              r_out_sof;
  logic              r_out_eol;
  logic              r_out_eof;

  logic              w_stall;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_abort;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_first_px;
  logic              w_drained;
  logic [ProdW-1:0]  w_prod_r [PPC];
  logic [ProdW-1:0]  w_prod_g [PPC];
  logic [ProdW-1:0]  w_prod_b [PPC];
  logic [SumW-1:0]   w_sum    [PPC];
  logic [PixW-1:0]   w_gray;

  assign w_stall    = r_out_valid && !out_ready;
  assign w_in_ready = (r_state == StRun) && !w_stall;
  assign w_in_fire  = in_valid && w_in_ready;
  // Abort is meaningless in idle, so it only acts once a frame has been started.
  assign w_abort    = abort && (r_state != StIdle);
  assign w_last_col = (r_x == r_width - 1'b1);
  assign w_last_row = (r_y == r_height - 1'b1);
  assign w_first_px = (r_x == '0) && (r_y == '0);
  // Last beat leaves the output register this cycle (or it is already gone).
  assign w_drained  = !r_s1_valid && (!r_out_valid || out_ready);

  for (genvar gi = 0; gi < PPC; gi++) begin : g_lane
    assign w_prod_r[gi] = ProdW'(in_red[gi*DATA_WIDTH +: DATA_WIDTH]) * CoefR;
    assign w_prod_g[gi] = ProdW'(in_green[gi*DATA_WIDTH +: DATA_WIDTH]) * CoefG;
    assign w_prod_b[gi] = ProdW'(in_blue[gi*DATA_WIDTH +: DATA_WIDTH]) * CoefB;
    assign w_sum[gi]    = SumW'(r_s1_r[gi]) + SumW'(r_s1_g[gi]) + SumW'(r_s1_b[gi]);
    assign w_gray[gi*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum[gi] >> 8);
  end

  // Frame FSM with geometry, position counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_width     <= '0;
      r_height    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= StIdle;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (start) begin
              r_width  <= cfg_width;
              r_height <= cfg_height;
              r_x      <= '0;
              r_y      <= '0;
              r_busy   <= 1'b1;
              r_state  <= (cfg_width == '0 || cfg_height == '0) ? StDone : StRun;
            end
          end
          StRun: begin
            if (w_in_fire) begin
              if (w_last_col) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
                if (w_last_row) r_state <= StDrain;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
          StDrain: begin
            if (w_drained) r_state <= StDone;
          end
          StDone: begin
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Two-stage conversion pipeline; holds completely while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_eol    <= 1'b0;
      r_s1_eof    <= 1'b0;
      for (int i = 0; i < PPC; i++) begin
        r_s1_r[i] <= '0;
        r_s1_g[i] <= '0;
        r_s1_b[i] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_gray  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else if (w_abort) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        for (int i = 0; i < PPC; i++) begin
          r_s1_r[i] <= w_prod_r[i];
          r_s1_g[i] <= w_prod_g[i];
          r_s1_b[i] <= w_prod_b[i];
        end
        r_s1_sof <= w_first_px;
        r_s1_eol <= w_last_col;
        r_s1_eof <= w_last_col && w_last_row;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_gray <= w_gray;
        r_out_sof  <= r_s1_sof;
        r_out_eol  <= r_s1_eol;
        r_out_eof  <= r_s1_eof;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_gray  = r_out_gray;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;
  assign out_eof   = r_out_eof;

endmodule
